// File: rtl/mempool_pkg.sv
// mempool_pkg: shared AMO encodings, queue-node state encoding and default request metadata
// Contents: amo_op_t with the LR/SC encodings used by the core and the bank adapter,
// qnode_state_t with the four queue-node states, and qnode_meta_t, the default
// request tag. The tag's lrwait bit marks successor updates and wake-up LRs.
package mempool_pkg;

    typedef logic [3:0] amo_op_t;
    localparam amo_op_t AmoNone = 4'h0;
    localparam amo_op_t AmoLr   = 4'hA;
    localparam amo_op_t AmoSc   = 4'hB;

    typedef logic [1:0] qnode_state_t;
    localparam qnode_state_t QnIdle     = 2'd0;
    localparam qnode_state_t QnReserved = 2'd1;
    localparam qnode_state_t QnScWait   = 2'd2;
    localparam qnode_state_t QnWakeUp   = 2'd3;

    typedef struct packed {
        logic [3:0] id;
        logic       lrwait;
    } qnode_meta_t;

endpackage

// File: rtl/lrwait_qnode.sv
// lrwait_qnode: core-side LRWait MCS queue node that records the successor and sends it a wake-up LR
// Ports: clk_i, rst_ni (async, active-low); core_req_* in / mem_req_* out (pass-through request
// path, taken over by the node while it issues a wake-up); mem_rsp_* in / core_rsp_* out
// (response path; responses tagged lrwait=1 are successor updates and are absorbed here).
// Optional: define QNODE_STATS_EN to add wakeup_cnt_o, a saturating count of wake-ups sent.
module lrwait_qnode
    import mempool_pkg::*;
#(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter type         metadata_t = qnode_meta_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   core_req_valid_i,
    output logic                   core_req_ready_o,
    input  logic [AddrWidth-1:0]   core_addr_i,
    input  logic [3:0]             core_amo_i,
    input  logic                   core_write_i,
    input  logic [DataWidth-1:0]   core_wdata_i,
    input  logic [DataWidth/8-1:0] core_be_i,
    input  metadata_t              core_meta_i,
    output logic                   core_rsp_valid_o,
    input  logic                   core_rsp_ready_i,
    output logic [DataWidth-1:0]   core_rdata_o,
    output metadata_t              core_meta_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [3:0]             mem_amo_o,
    output logic                   mem_write_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output metadata_t              mem_meta_o,
    input  logic                   mem_rsp_valid_i,
    output logic                   mem_rsp_ready_o,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  metadata_t              mem_meta_i
`ifdef QNODE_STATS_EN
    ,
    output logic [15:0]            wakeup_cnt_o
`endif
);

    localparam int unsigned MetaWidth = $bits(metadata_t);

    qnode_state_t         state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    metadata_t            succ_q, own_meta_q, wake_meta;
    logic                 succ_valid_q;
    logic                 wake, core_hs, lr_hs, sc_hs, succ_upd, rsp_hs, wake_hs;

    assign wake     = state_q == QnWakeUp;
    assign core_hs  = !wake && core_req_valid_i && mem_req_ready_i;
    assign lr_hs    = core_hs && core_amo_i == AmoLr && !core_meta_i.lrwait;
    assign sc_hs    = core_hs && core_amo_i == AmoSc;
    assign succ_upd = mem_rsp_valid_i && mem_meta_i.lrwait;
    assign rsp_hs   = mem_rsp_valid_i && !mem_meta_i.lrwait && core_rsp_ready_i;
    assign wake_hs  = wake && mem_req_ready_i;

    always_comb begin
        wake_meta        = own_meta_q;
        wake_meta.lrwait = 1'b1;
    end

    // While waking the successor the node owns the memory port and stalls the core.
    assign core_req_ready_o = !wake && mem_req_ready_i;
    assign mem_req_valid_o  = wake || core_req_valid_i;
    assign mem_addr_o       = wake ? addr_q : core_addr_i;
    assign mem_amo_o        = wake ? AmoLr : core_amo_i;
    assign mem_write_o      = !wake && core_write_i;
    assign mem_wdata_o      = wake ? DataWidth'(succ_q) : core_wdata_i;
    assign mem_be_o         = wake ? '1 : core_be_i;
    assign mem_meta_o       = wake ? wake_meta : core_meta_i;

    // Successor updates are always consumed locally and never reach the core.
    assign core_rsp_valid_o = mem_rsp_valid_i && !mem_meta_i.lrwait;
    assign mem_rsp_ready_o  = mem_meta_i.lrwait || core_rsp_ready_i;
    assign core_rdata_o     = mem_rdata_i;
    assign core_meta_o      = mem_meta_i;

    // A successor arriving together with the exit cycle counts as already recorded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            QnIdle:     state_d = succ_upd ? QnWakeUp : lr_hs ? QnReserved : QnIdle;
            QnReserved: state_d = (sc_hs && core_addr_i == addr_q) ? QnScWait : QnReserved;
            QnScWait:   state_d = !rsp_hs ? QnScWait :
                                  mem_rdata_i != '0 ? QnReserved :
                                  (succ_valid_q || succ_upd) ? QnWakeUp : QnIdle;
            default:    state_d = wake_hs ? QnIdle : QnWakeUp;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= QnIdle;
            addr_q       <= '0;
            own_meta_q   <= '0;
            succ_q       <= '0;
            succ_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (lr_hs && state_q != QnScWait && state_d == QnReserved) begin
                addr_q     <= core_addr_i;
                own_meta_q <= core_meta_i;
            end
            if (wake_hs) begin
                succ_valid_q <= 1'b0;
            end else if (succ_upd && !succ_valid_q) begin
                succ_q       <= metadata_t'(mem_rdata_i[MetaWidth-1:0]);
                succ_valid_q <= 1'b1;
            end
        end
    end

`ifdef QNODE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wakeup_cnt_o <= '0;
        else if (wake_hs && wakeup_cnt_o != 16'hFFFF) wakeup_cnt_o <= wakeup_cnt_o + 16'd1;
    end
`endif

    a_single_succ: assert property (@(posedge clk_i) disable iff (!rst_ni) succ_upd |-> !succ_valid_q)
        else $error("lrwait_qnode: second successor update while one is pending");
    a_core_lr_plain: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (core_hs && core_amo_i == AmoLr) |-> !core_meta_i.lrwait)
        else $error("lrwait_qnode: core LR carries lrwait=1");

endmodule

// File: tb/tb_lrwait_qnode.sv
// tb_lrwait_qnode: scoreboard bench for lrwait_qnode with a transaction-level queue-node model
`timescale 1ns/1ps
module tb_lrwait_qnode;
    import mempool_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    amo;
        logic          write;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        qnode_meta_t   meta;
    } mreq_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        qnode_meta_t   meta;
    } rsp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          core_req_valid_i, core_req_ready_o;
    logic [AW-1:0] core_addr_i;
    logic [3:0]    core_amo_i;
    logic          core_write_i;
    logic [DW-1:0] core_wdata_i;
    logic [3:0]    core_be_i;
    qnode_meta_t   core_meta_i;
    logic          core_rsp_valid_o, core_rsp_ready_i;
    logic [DW-1:0] core_rdata_o;
    qnode_meta_t   core_meta_o;
    logic          mem_req_valid_o, mem_req_ready_i;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_amo_o;
    logic          mem_write_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_be_o;
    qnode_meta_t   mem_meta_o;
    logic          mem_rsp_valid_i, mem_rsp_ready_o;
    logic [DW-1:0] mem_rdata_i;
    qnode_meta_t   mem_meta_i;
`ifdef QNODE_STATS_EN
    logic [15:0]   wakeup_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    lrwait_qnode #(.AddrWidth(AW), .DataWidth(DW), .metadata_t(qnode_meta_t)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
        .core_addr_i(core_addr_i), .core_amo_i(core_amo_i), .core_write_i(core_write_i),
        .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_meta_i(core_meta_i),
        .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
        .core_rdata_o(core_rdata_o), .core_meta_o(core_meta_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_amo_o(mem_amo_o), .mem_write_o(mem_write_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_meta_o(mem_meta_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rdata_i(mem_rdata_i), .mem_meta_i(mem_meta_i)
`ifdef QNODE_STATS_EN
        , .wakeup_cnt_o(wakeup_cnt_o)
`endif
    );

    int    checks = 0;
    int    failures = 0;
    bit    hold_low = 1'b0;
    mreq_t exp_req[$];
    rsp_t  exp_rsp[$];

    // Reference model of the node at transaction level: whether this core holds a
    // reservation, whether its SC is outstanding, and the successors it owes a wake-up.
    bit            m_resv, m_scwait;
    logic [AW-1:0] m_addr;
    qnode_meta_t   m_own;
    logic [4:0]    m_succ[$];
    int            m_wakes;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_wake();
        logic [4:0] s = m_succ.pop_front();
        exp_req.push_back('{addr: m_addr, amo: AmoLr, write: 1'b0, wdata: 32'(s), be: 4'hF,
                            meta: '{id: m_own.id, lrwait: 1'b1}});
        m_wakes++;
    endfunction

    function automatic void model_req(input logic [3:0] amo, input logic [AW-1:0] addr, input qnode_meta_t m);
        if (amo == AmoLr && !m.lrwait) begin
            m_resv = 1'b1;
            m_addr = addr;
            m_own  = m;
        end else if (amo == AmoSc && m_resv && addr == m_addr) begin
            m_scwait = 1'b1;
        end
    endfunction

    function automatic void model_rsp(input logic [DW-1:0] rdata);
        if (m_scwait) begin
            m_scwait = 1'b0;
            if (rdata == 0) begin
                m_resv = 1'b0;
                if (m_succ.size() != 0) push_wake();
            end
        end
    endfunction

    function automatic void model_succ(input logic [4:0] v);
        m_succ.push_back(v);
        if (!m_resv && !m_scwait) push_wake();
    endfunction

    function automatic void model_reset();
        m_resv = 1'b0;
        m_scwait = 1'b0;
        m_addr = '0;
        m_own = '0;
        m_succ.delete();
        exp_req.delete();
        exp_rsp.delete();
        m_wakes = 0;
    endfunction

    initial begin
        mem_req_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_req_ready_i = !hold_low && ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk_i) begin : monitor
        mreq_t a;
        rsp_t  r;
        if (rst_ni) begin
            if (mem_req_valid_o && mem_req_ready_i) begin
                a = '{addr: mem_addr_o, amo: mem_amo_o, write: mem_write_o, wdata: mem_wdata_o,
                      be: mem_be_o, meta: mem_meta_o};
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_req unexpected actual=%0h required=none", a);
                end else check("mem_req", a, exp_req.pop_front());
            end
            if (mem_rsp_valid_i && !mem_meta_i.lrwait)
                check("rsp_ready_fwd", mem_rsp_ready_o, core_rsp_ready_i);
            if (core_rsp_valid_o && core_rsp_ready_i) begin
                r = '{rdata: core_rdata_o, meta: core_meta_o};
                if (exp_rsp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL core_rsp unexpected actual=%0h required=none", r);
                end else check("core_rsp", r, exp_rsp.pop_front());
            end
        end
    end

    task automatic core_op(input logic [3:0] amo, input logic [AW-1:0] addr, input logic wr,
                           input logic [3:0] id, input logic [DW-1:0] rdata, input bit hold);
        qnode_meta_t m;
        bit r;
        int n;
        m = '{id: id, lrwait: 1'b0};
        core_req_valid_i = 1'b1;
        core_amo_i = amo;
        core_addr_i = addr;
        core_write_i = wr;
        core_wdata_i = $urandom;
        core_be_i = wr ? 4'($urandom_range(1, 15)) : 4'hF;
        core_meta_i = m;
        exp_req.push_back('{addr: addr, amo: amo, write: wr, wdata: core_wdata_i, be: core_be_i, meta: m});
        model_req(amo, addr, m);
        n = 0;
        @(negedge clk_i);
        while (!core_req_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!core_req_ready_o) begin
            checks++;
            failures++;
            $display("FAIL req_handshake timeout actual=0 required=1");
        end
        @(posedge clk_i);
        #1;
        core_req_valid_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = rdata;
        mem_meta_i = m;
        exp_rsp.push_back('{rdata: rdata, meta: m});
        model_rsp(rdata);
        n = 0;
        do begin
            r = n > 8 || $urandom_range(0, 2) != 0;
            core_rsp_ready_i = r;
            if (r && hold) hold_low = 1'b1;
            @(posedge clk_i);
            #1;
            n++;
        end while (!r);
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i = '0;
        mem_meta_i = '0;
        core_rsp_ready_i = 1'b0;
    endtask

    task automatic succ_update(input logic [4:0] v);
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = {27'($urandom), v};
        mem_meta_i = '{id: 4'($urandom), lrwait: 1'b1};
        core_rsp_ready_i = 1'($urandom);
        model_succ(v);
        @(negedge clk_i);
        check("succ_rsp_ready", mem_rsp_ready_o, 1'b1);
        check("succ_not_forwarded", core_rsp_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i = '0;
        mem_meta_i = '0;
        core_rsp_ready_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_req.size() != 0 && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (exp_req.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending actual=%0d required=0", exp_req.size());
            exp_req.delete();
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            check("no_mem_req", mem_req_valid_o, 1'b0);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [3:0]    id;
        int            k;
        core_req_valid_i = 1'b0;
        core_addr_i = '0;
        core_amo_i = '0;
        core_write_i = 1'b0;
        core_wdata_i = '0;
        core_be_i = '0;
        core_meta_i = '0;
        core_rsp_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i = '0;
        mem_meta_i = '0;
        model_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_mem_req_valid", mem_req_valid_o, 1'b0);
        check("rst_core_req_ready", core_req_ready_o, mem_req_ready_i);
        check("rst_core_rsp_valid", core_rsp_valid_o, 1'b0);
`ifdef QNODE_STATS_EN
        check("rst_wakeup_cnt", wakeup_cnt_o, 16'd0);
`endif
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        // Successful SC with nobody queued behind: no wake-up.
        core_op(AmoLr, 32'h100, 1'b0, 4'd3, $urandom, 1'b0);
        core_op(AmoSc, 32'h100, 1'b0, 4'd3, 32'd0, 1'b0);
        drain();
        quiet(4);
        // Successor queued before the SC completes.
        core_op(AmoLr, 32'h100, 1'b0, 4'd3, $urandom, 1'b0);
        succ_update(5'd5);
        core_op(AmoSc, 32'h100, 1'b0, 4'd3, 32'd0, 1'b0);
        drain();
        // Successor arriving after the SC has already completed.
        core_op(AmoLr, 32'h100, 1'b0, 4'd3, $urandom, 1'b0);
        core_op(AmoSc, 32'h100, 1'b0, 4'd3, 32'd0, 1'b0);
        quiet(3);
        succ_update(5'd7);
        drain();
        // Wake-up held off by the memory for four cycles.
        core_op(AmoLr, 32'h100, 1'b0, 4'd3, $urandom, 1'b0);
        succ_update(5'd9);
        core_op(AmoSc, 32'h100, 1'b0, 4'd3, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("stall_valid", mem_req_valid_o, 1'b1);
            check("stall_addr", mem_addr_o, 32'h100);
            check("stall_wdata", mem_wdata_o, 32'd9);
            check("stall_core_ready", core_req_ready_o, 1'b0);
        end
        @(posedge clk_i);
        #1;
        hold_low = 1'b0;
        drain();
        // Failed SC keeps the reservation and the successor; retry wakes it.
        core_op(AmoLr, 32'h100, 1'b0, 4'd3, $urandom, 1'b0);
        succ_update(5'd3);
        core_op(AmoSc, 32'h100, 1'b0, 4'd3, 32'd1, 1'b0);
        quiet(3);
        core_op(AmoSc, 32'h100, 1'b0, 4'd3, 32'd0, 1'b0);
        drain();
        // Reset while a wake-up is pending drops it.
        core_op(AmoLr, 32'h100, 1'b0, 4'd3, $urandom, 1'b0);
        succ_update(5'd4);
        core_op(AmoSc, 32'h100, 1'b0, 4'd3, 32'd0, 1'b1);
        @(negedge clk_i);
        check("pre_rst_wake_valid", mem_req_valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("in_rst_mem_req_valid", mem_req_valid_o, 1'b0);
        model_reset();
        repeat (2) @(negedge clk_i);
        hold_low = 1'b0;
        rst_ni = 1'b1;
        quiet(5);
`ifdef QNODE_STATS_EN
        check("post_rst_wakeup_cnt", wakeup_cnt_o, 16'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            core_op(AmoLr, 32'h200, 1'b0, 4'(i + 1), $urandom, 1'b0);
            succ_update(5'(i + 10));
            core_op(AmoSc, 32'h200, 1'b0, 4'(i + 1), 32'd0, 1'b0);
            drain();
        end
`ifdef QNODE_STATS_EN
        check("wakeup_cnt_three", wakeup_cnt_o, 16'(m_wakes));
`endif
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            a = 32'h100 * $urandom_range(1, 3);
            id = 4'($urandom);
            if (k < 3) core_op(AmoLr, a, 1'b0, id, $urandom, 1'b0);
            else if (k < 6) core_op(AmoSc, (m_resv && k != 5) ? m_addr : a, 1'b0, id, 32'($urandom_range(0, 1)), 1'b0);
            else if (k < 8) core_op(AmoNone, a, 1'($urandom), id, $urandom, 1'b0);
            else begin
                drain();
                if (m_succ.size() == 0) succ_update(5'($urandom));
            end
        end
        drain();
        check("rsp_queue_empty", exp_rsp.size(), 0);
`ifdef QNODE_STATS_EN
        check("wakeup_cnt_final", wakeup_cnt_o, 16'(m_wakes));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
